// File: rtl/mux_pkg.sv
// Shared definitions for the operand-select pipeline: default sizes, select codes
// and the payload layout carried through the register slice.
package mux_pkg;

    localparam int unsigned MUX_DEF_WIDTH  = 24;
    localparam int unsigned MUX_DEF_NUM_IN = 4;
    localparam int unsigned MUX_DEF_SEL_W  = 2;

    localparam int unsigned SEL_B    = 0;
    localparam int unsigned SEL_ONE  = 1;
    localparam int unsigned SEL_IMM  = 2;
    localparam int unsigned SEL_ADDR = 3;

    // Payload at the default sizes; parametrised users declare the same layout locally.
    typedef struct packed {
        logic [MUX_DEF_WIDTH-1:0] data;
        logic [MUX_DEF_SEL_W-1:0] sel;
        logic                     oor;
    } mux_item_t;

    // Packed width of a {data, sel, oor} payload for arbitrary sizes.
    function automatic int unsigned mux_item_w(input int unsigned width, input int unsigned sel_w);
        return width + sel_w + 1;
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic 2-entry valid/ready register slice: one output register plus one skid entry,
// with in_ready taken straight from a flop.
module pipe_skid_reg #(
    parameter int unsigned PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_payload,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_payload
);

    logic          skid_valid;
    logic [PW-1:0] skid_payload;
    logic          out_valid_d;
    logic [PW-1:0] out_payload_d;
    logic          skid_valid_d;
    logic [PW-1:0] skid_payload_d;
    logic          accept;

    assign accept = in_valid && in_ready;

    // Skid entry always drains ahead of new input, which keeps ordering FIFO.
    always_comb begin
        out_valid_d    = out_valid;
        out_payload_d  = out_payload;
        skid_valid_d   = skid_valid;
        skid_payload_d = skid_payload;
        if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_valid_d   = 1'b1;
                out_payload_d = skid_payload;
                skid_valid_d  = 1'b0;
            end else if (accept) begin
                out_valid_d   = 1'b1;
                out_payload_d = in_payload;
            end else begin
                out_valid_d   = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d   = 1'b1;
            skid_payload_d = in_payload;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_payload  <= '0;
            skid_valid   <= 1'b0;
            skid_payload <= '0;
            in_ready     <= 1'b1;
        end else begin
            out_valid    <= out_valid_d;
            out_payload  <= out_payload_d;
            skid_valid   <= skid_valid_d;
            skid_payload <= skid_payload_d;
            in_ready     <= !skid_valid_d;
        end
    end

endmodule

// File: rtl/mux_sel_pipe.sv
// N-way operand selector feeding a registered valid/ready slice; out-of-range selects
// yield DEFAULT_VAL, are tagged with oor and latch the sticky sel_err flag.
module mux_sel_pipe
    import mux_pkg::*;
#(
    parameter int unsigned      WIDTH       = MUX_DEF_WIDTH,
    parameter int unsigned      NUM_IN      = MUX_DEF_NUM_IN,
    parameter int unsigned      SEL_W       = MUX_DEF_SEL_W,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_oor,
    output logic                    sel_err,
    input  logic                    err_clr
);

    localparam int unsigned PW = mux_item_w(WIDTH, SEL_W);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
        logic             oor;
    } item_t;

    item_t in_item;
    item_t out_item;
    logic  accept;

    assign accept = in_valid && in_ready;

    // Explicit compare per input so an out-of-range code never indexes past in_data.
    always_comb begin
        in_item.data = DEFAULT_VAL;
        in_item.sel  = sel;
        in_item.oor  = 1'b1;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (32'(sel) == k) begin
                in_item.data = in_data[k*WIDTH +: WIDTH];
                in_item.oor  = 1'b0;
            end
        end
    end

    pipe_skid_reg #(
        .PW (PW)
    ) u_slice (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  (PW'(in_item)),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (out_item)
    );

    assign out_data = out_item.data;
    assign out_sel  = out_item.sel;
    assign out_oor  = out_item.oor;

    // Set beats clear when both happen in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else if (accept && in_item.oor) begin
            sel_err <= 1'b1;
        end else if (err_clr) begin
            sel_err <= 1'b0;
        end
    end

endmodule
